// File: rtl/g07_sched_pkg.sv
// g07 bus grant scheduler: shared types and constants.
// Holds the FSM state enum, master count, default quotas, onehot2idx.
package g07_sched_pkg;

    localparam int N_MST       = 7;
    localparam int CW          = 7;
    localparam int DEF_WINDOW  = 100;
    localparam int DEF_TIMEOUT = 64;

    // Guaranteed completions per window, master 6 in the top slice.
    localparam logic [N_MST*CW-1:0] DEF_QUOTA = {
        7'd16, 7'd6, 7'd25, 7'd19, 7'd6, 7'd13, 7'd15
    };

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_e;

    // OR-accumulation is exact for a one-hot (or zero) input.
    function automatic logic [2:0] onehot2idx(
        input logic [N_MST-1:0] oh
    );
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < N_MST; i++) begin
            if (oh[i]) idx = idx | 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/g07_rr_pick.sv
// g07 round-robin picker: first requester after rr_ptr, wrapping.
// Ports: req_i (mask), rr_ptr_i (last served) -> win_oh_o, win_idx_o.
module g07_rr_pick
    import g07_sched_pkg::*;
(
    input  logic [N_MST-1:0] req_i,
    input  logic [2:0]       rr_ptr_i,
    output logic [N_MST-1:0] win_oh_o,
    output logic [2:0]       win_idx_o
);

    logic [3:0] pos;
    logic       found;

    // Scan rr_ptr+1 .. rr_ptr+N_MST; the last offset revisits rr_ptr.
    always_comb begin
        win_oh_o = '0;
        found    = 1'b0;
        pos      = '0;
        for (int k = 1; k <= N_MST; k++) begin
            pos = {1'b0, rr_ptr_i} + 4'(k);
            if (pos >= 4'(N_MST)) pos = pos - 4'(N_MST);
            if (!found && req_i[pos[2:0]]) begin
                found              = 1'b1;
                win_oh_o[pos[2:0]] = 1'b1;
            end
        end
        win_idx_o = onehot2idx(win_oh_o);
    end

endmodule

// File: rtl/g07_quota_sched.sv
// g07 quota-weighted grant scheduler with round-robin and watchdog.
// Ports: sysClk, Breset_n, need/tdone/dec_hit in; ack, gnt_valid,
// gnt_id, txn_abort, err_id, window_wrap out (all registered).
module g07_quota_sched
    import g07_sched_pkg::*;
#(
    parameter int                    WINDOW  = DEF_WINDOW,
    parameter int                    TIMEOUT = DEF_TIMEOUT,
    parameter logic [N_MST*CW-1:0]   QUOTA   = DEF_QUOTA
) (
    input  logic             sysClk,
    input  logic             Breset_n,
    input  logic [N_MST-1:0] need,
    input  logic             tdone,
    input  logic             dec_hit,
    output logic [N_MST-1:0] ack,
    output logic             gnt_valid,
    output logic [2:0]       gnt_id,
    output logic             txn_abort,
    output logic [2:0]       err_id,
    output logic             window_wrap
);

    localparam int WDW = $clog2(TIMEOUT);

    state_e           state_q;
    logic [N_MST-1:0] ack_q;
    logic             gnt_valid_q;
    logic [2:0]       gnt_id_q;
    logic             txn_abort_q;
    logic [2:0]       err_id_q;
    logic             window_wrap_q;
    logic [2:0]       rr_ptr_q;
    logic [CW-1:0]    cnt_q [N_MST];
    logic [CW-1:0]    total_q;
    logic [WDW-1:0]   wd_q;

    logic [N_MST-1:0] exhausted_d;
    logic [N_MST-1:0] pick_d;
    logic [N_MST-1:0] win_oh_d;
    logic [2:0]       win_idx_d;
    logic             wrap_d;
    logic             abort_d;

    // Quota-eligible requesters first; if all are spent, serve
    // every requester round-robin as overflow.
    always_comb begin
        exhausted_d = '0;
        for (int i = 0; i < N_MST; i++) begin
            exhausted_d[i] = cnt_q[i] >= QUOTA[i*CW +: CW];
        end
        pick_d = need & ~exhausted_d;
        if (pick_d == '0) pick_d = need;
    end

    assign wrap_d  = total_q == CW'(WINDOW - 1);
    assign abort_d = !dec_hit || (wd_q == WDW'(TIMEOUT - 1));

    g07_rr_pick u_pick (
        .req_i     (pick_d),
        .rr_ptr_i  (rr_ptr_q),
        .win_oh_o  (win_oh_d),
        .win_idx_o (win_idx_d)
    );

    always_ff @(posedge sysClk or negedge Breset_n) begin
        if (!Breset_n) begin
            state_q       <= IDLE;
            ack_q         <= '0;
            gnt_valid_q   <= 1'b0;
            gnt_id_q      <= '0;
            txn_abort_q   <= 1'b0;
            err_id_q      <= '0;
            window_wrap_q <= 1'b0;
            rr_ptr_q      <= 3'(N_MST - 1);
            total_q       <= '0;
            wd_q          <= '0;
            for (int i = 0; i < N_MST; i++) cnt_q[i] <= '0;
        end else begin
            txn_abort_q   <= 1'b0;
            window_wrap_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (need != '0) begin
                        state_q     <= GRANT;
                        ack_q       <= win_oh_d;
                        gnt_id_q    <= win_idx_d;
                        gnt_valid_q <= 1'b1;
                        wd_q        <= '0;
                    end
                end
                GRANT: begin
                    if (tdone) begin
                        state_q     <= RELEASE;
                        ack_q       <= '0;
                        gnt_valid_q <= 1'b0;
                        rr_ptr_q    <= gnt_id_q;
                        // The closing completion clears rather than counts.
                        if (wrap_d) begin
                            for (int i = 0; i < N_MST; i++) cnt_q[i] <= '0;
                            total_q       <= '0;
                            window_wrap_q <= 1'b1;
                        end else begin
                            if (cnt_q[gnt_id_q] != '1) begin
                                cnt_q[gnt_id_q] <= cnt_q[gnt_id_q] + 1'b1;
                            end
                            total_q <= total_q + 1'b1;
                        end
                    end else if (abort_d) begin
                        state_q     <= RELEASE;
                        ack_q       <= '0;
                        gnt_valid_q <= 1'b0;
                        rr_ptr_q    <= gnt_id_q;
                        txn_abort_q <= 1'b1;
                        err_id_q    <= gnt_id_q;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                RELEASE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack         = ack_q;
    assign gnt_valid   = gnt_valid_q;
    assign gnt_id      = gnt_id_q;
    assign txn_abort   = txn_abort_q;
    assign err_id      = err_id_q;
    assign window_wrap = window_wrap_q;

endmodule
